// File: rtl/rvvi_pkg.sv
// rvvi_pkg: types and constants shared by the RVVI retire tracer.
//   retire_rec_t : one retirement event, as it is buffered in the record FIFO
//   wb_onehot    : turns a register write (enable + address) into a one-hot flag vector
// Optional feature macro: RVVI_TRACE_FPR_EN adds the FPR write fields to the record.
package rvvi_pkg;

    localparam int NUM_REGS  = 32;
    localparam int RVVI_ILEN = 32;
    localparam int RVVI_XLEN = 32;
`ifdef RVVI_TRACE_FPR_EN
    localparam int RVVI_FLEN = 32;
`endif

    typedef struct packed {
        logic [RVVI_ILEN-1:0] insn;
        logic [RVVI_XLEN-1:0] pc;
        logic [RVVI_XLEN-1:0] next_pc;
        logic                 trap;
        logic                 halt;
        logic [1:0]           mode;
        logic [1:0]           ixl;
        logic                 rd_we;
        logic [4:0]           rd_addr;
        logic [RVVI_XLEN-1:0] rd_data;
`ifdef RVVI_TRACE_FPR_EN
        logic                 fd_we;
        logic [4:0]           fd_addr;
        logic [RVVI_FLEN-1:0] fd_data;
`endif
    } retire_rec_t;

    // skip_zero drops writes to register 0 (the hardwired x0).
    function automatic logic [NUM_REGS-1:0] wb_onehot(input logic       we,
                                                      input logic [4:0] addr,
                                                      input logic       skip_zero);
        logic [NUM_REGS-1:0] oh;
        oh = {NUM_REGS{1'b0}};
        if (we && !(skip_zero && (addr == 5'd0))) begin
            oh[addr] = 1'b1;
        end else begin
            oh = {NUM_REGS{1'b0}};
        end
        return oh;
    endfunction

endpackage

// File: rtl/rvvi_trace_fifo.sv
// rvvi_trace_fifo: first-word-fall-through FIFO of retire records.
//   clk, reset        : clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data   : write request and record; ignored while full
//   full              : no room for another record
//   pop               : consume the head record; ignored while empty
//   empty, head       : head is the oldest record, readable combinationally
module rvvi_trace_fifo
    import rvvi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  retire_rec_t push_data,
    output logic        full,
    input  logic        pop,
    output logic        empty,
    output retire_rec_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    retire_rec_t mem_r [DEPTH];
    // One extra pointer bit tells full from empty when the indices match.
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic        do_push_s;
    logic        do_pop_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r[AW-1:0]];

    // Read/write pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Record storage; contents only matter between push and pop, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/rvvi_retire_tracer.sv
// rvvi_retire_tracer: DUT-side RVVI retire record producer (hart 0, retire slot 0).
// Buffers one retirement event per cycle and presents each as an RVVI record
// carrying the full X register state after that instruction.
//   clk, reset                 : clock, asynchronous active-high reset
//   in_valid/in_ready          : retirement event handshake from writeback
//   in_insn, in_pc, in_next_pc, in_trap, in_halt, in_mode, in_ixl : event fields
//   in_rd_we/addr/data         : GPR write of the event
//   in_fd_we/addr/data         : FPR write of the event (RVVI_TRACE_FPR_EN only)
//   valid/out_ready            : record handshake towards the RVVI consumer
//   order, insn, trap, halt, intr, mode, ixl, pc_rdata, pc_wdata : record fields
//   x_wdata, x_wb              : X file after the instruction, one-hot write flag
//   f_wdata, f_wb              : F file equivalents (RVVI_TRACE_FPR_EN only)
// Optional feature macro: RVVI_TRACE_FPR_EN.
// All record outputs read 0 while no record is present (x_wdata shows the shadow file).
module rvvi_retire_tracer
    import rvvi_pkg::*;
#(
    parameter int ILEN  = 32,
    parameter int XLEN  = 32,
`ifdef RVVI_TRACE_FPR_EN
    parameter int FLEN  = 32,
`endif
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ILEN-1:0]                in_insn,
    input  logic [XLEN-1:0]                in_pc,
    input  logic [XLEN-1:0]                in_next_pc,
    input  logic                           in_trap,
    input  logic                           in_halt,
    input  logic [1:0]                     in_mode,
    input  logic [1:0]                     in_ixl,
    input  logic                           in_rd_we,
    input  logic [4:0]                     in_rd_addr,
    input  logic [XLEN-1:0]                in_rd_data,
`ifdef RVVI_TRACE_FPR_EN
    input  logic                           in_fd_we,
    input  logic [4:0]                     in_fd_addr,
    input  logic [FLEN-1:0]                in_fd_data,
    output logic [NUM_REGS-1:0][FLEN-1:0]  f_wdata,
    output logic [NUM_REGS-1:0]            f_wb,
`endif
    input  logic                           out_ready,
    output logic                           valid,
    output logic [63:0]                    order,
    output logic [ILEN-1:0]                insn,
    output logic                           trap,
    output logic                           halt,
    output logic                           intr,
    output logic [1:0]                     mode,
    output logic [1:0]                     ixl,
    output logic [XLEN-1:0]                pc_rdata,
    output logic [XLEN-1:0]                pc_wdata,
    output logic [NUM_REGS-1:0][XLEN-1:0]  x_wdata,
    output logic [NUM_REGS-1:0]            x_wb
);

    retire_rec_t                  rec_in_s;
    retire_rec_t                  head_s;
    logic                         fifo_full_s;
    logic                         fifo_empty_s;
    logic                         pop_s;
    logic [63:0]                  order_r;
    logic                         intr_r;
    logic [NUM_REGS-1:0][XLEN-1:0] x_shadow_r;
`ifdef RVVI_TRACE_FPR_EN
    logic [NUM_REGS-1:0][FLEN-1:0] f_shadow_r;
`endif

    // Pack the incoming event into a record.
    always_comb begin
        rec_in_s         = '{default: '0};
        rec_in_s.insn    = in_insn;
        rec_in_s.pc      = in_pc;
        rec_in_s.next_pc = in_next_pc;
        rec_in_s.trap    = in_trap;
        rec_in_s.halt    = in_halt;
        rec_in_s.mode    = in_mode;
        rec_in_s.ixl     = in_ixl;
        rec_in_s.rd_we   = in_rd_we;
        rec_in_s.rd_addr = in_rd_addr;
        rec_in_s.rd_data = in_rd_data;
`ifdef RVVI_TRACE_FPR_EN
        rec_in_s.fd_we   = in_fd_we;
        rec_in_s.fd_addr = in_fd_addr;
        rec_in_s.fd_data = in_fd_data;
`endif
    end

    rvvi_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid),
        .push_data (rec_in_s),
        .full      (fifo_full_s),
        .pop       (pop_s),
        .empty     (fifo_empty_s),
        .head      (head_s)
    );

    assign in_ready = !fifo_full_s;
    assign valid    = !fifo_empty_s;
    assign pop_s    = valid && out_ready;

    // Record fields from the FIFO head; the register views overlay the head's write on the shadow files.
    always_comb begin
        order    = 64'd0;
        insn     = {ILEN{1'b0}};
        trap     = 1'b0;
        halt     = 1'b0;
        intr     = 1'b0;
        mode     = 2'd0;
        ixl      = 2'd0;
        pc_rdata = {XLEN{1'b0}};
        pc_wdata = {XLEN{1'b0}};
        x_wb     = {NUM_REGS{1'b0}};
        x_wdata  = x_shadow_r;
`ifdef RVVI_TRACE_FPR_EN
        f_wb     = {NUM_REGS{1'b0}};
        f_wdata  = f_shadow_r;
`endif
        if (valid) begin
            // The counter holds the number of records already popped.
            order    = order_r + 64'd1;
            insn     = head_s.insn;
            trap     = head_s.trap;
            halt     = head_s.halt;
            intr     = intr_r;
            mode     = head_s.mode;
            ixl      = head_s.ixl;
            pc_rdata = head_s.pc;
            pc_wdata = head_s.next_pc;
            x_wb     = wb_onehot(head_s.rd_we, head_s.rd_addr, 1'b1);
`ifdef RVVI_TRACE_FPR_EN
            f_wb     = wb_onehot(head_s.fd_we, head_s.fd_addr, 1'b0);
`endif
        end else begin
            order = 64'd0;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (x_wb[i]) begin
                x_wdata[i] = head_s.rd_data;
            end else begin
                x_wdata[i] = x_shadow_r[i];
            end
`ifdef RVVI_TRACE_FPR_EN
            if (f_wb[i]) begin
                f_wdata[i] = head_s.fd_data;
            end else begin
                f_wdata[i] = f_shadow_r[i];
            end
`endif
        end
    end

    // Per-pop architectural state: order count, pending interrupt flag and shadow register files.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            order_r    <= 64'd0;
            intr_r     <= 1'b0;
            x_shadow_r <= {(NUM_REGS*XLEN){1'b0}};
`ifdef RVVI_TRACE_FPR_EN
            f_shadow_r <= {(NUM_REGS*FLEN){1'b0}};
`endif
        end else if (pop_s) begin
            order_r    <= order_r + 64'd1;
            // A trapped record means the next record is the first one of the handler.
            intr_r     <= head_s.trap;
            x_shadow_r <= x_wdata;
`ifdef RVVI_TRACE_FPR_EN
            f_shadow_r <= f_wdata;
`endif
        end
    end

endmodule

// File: tb/tb_rvvi_retire_tracer.sv
module tb_rvvi_retire_tracer;

    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_insn = 32'd0;
    logic [31:0]       in_pc = 32'd0;
    logic [31:0]       in_next_pc = 32'd0;
    logic              in_trap = 1'b0;
    logic              in_halt = 1'b0;
    logic [1:0]        in_mode = 2'd0;
    logic [1:0]        in_ixl = 2'd0;
    logic              in_rd_we = 1'b0;
    logic [4:0]        in_rd_addr = 5'd0;
    logic [31:0]       in_rd_data = 32'd0;
    logic              out_ready = 1'b1;
    logic              valid;
    logic [63:0]       order;
    logic [31:0]       insn;
    logic              trap, halt, intr;
    logic [1:0]        mode, ixl;
    logic [31:0]       pc_rdata, pc_wdata;
    logic [31:0][31:0] x_wdata;
    logic [31:0]       x_wb;

    int n_checks = 0;
    int n_err    = 0;

    rvvi_retire_tracer #(.ILEN(32), .XLEN(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
        .in_pc(in_pc), .in_next_pc(in_next_pc), .in_trap(in_trap), .in_halt(in_halt),
        .in_mode(in_mode), .in_ixl(in_ixl), .in_rd_we(in_rd_we),
        .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
        .out_ready(out_ready), .valid(valid), .order(order), .insn(insn),
        .trap(trap), .halt(halt), .intr(intr), .mode(mode), .ixl(ixl),
        .pc_rdata(pc_rdata), .pc_wdata(pc_wdata), .x_wdata(x_wdata), .x_wb(x_wb)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: a queue of accepted events ----------------
    typedef struct {
        logic [31:0] insn, pc, npc;
        logic        trap, halt;
        logic [1:0]  mode, ixl;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } ev_t;

    ev_t         q[$];
    logic [31:0] shadow_m [32];
    logic [63:0] popped_m = 64'd0;
    logic        after_trap_m = 1'b0;

    initial for (int i = 0; i < 32; i++) shadow_m[i] = 32'd0;

    function automatic ev_t cur_event();
        ev_t e;
        e.insn = in_insn; e.pc = in_pc; e.npc = in_next_pc; e.trap = in_trap;
        e.halt = in_halt; e.mode = in_mode; e.ixl = in_ixl; e.we = in_rd_we;
        e.rd = in_rd_addr; e.data = in_rd_data;
        return e;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            for (int i = 0; i < 32; i++) shadow_m[i] <= 32'd0;
            popped_m     <= 64'd0;
            after_trap_m <= 1'b0;
        end else if (out_ready && q.size() != 0) begin
            if (q[0].we && q[0].rd != 5'd0) shadow_m[q[0].rd] <= q[0].data;
            popped_m     <= popped_m + 64'd1;
            after_trap_m <= q[0].trap;
            q.pop_front();
            // room was judged before the pop: a full FIFO refuses the push
            if (in_valid && q.size() < DEPTH - 1) q.push_back(cur_event());
        end else if (in_valid && q.size() < DEPTH) begin
            q.push_back(cur_event());
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic [31:0][31:0] ex;
        logic [31:0]       ewb;
        chk("valid", {63'd0, valid}, {63'd0, q.size() != 0});
        chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < DEPTH});
        if (q.size() != 0) begin
            ewb = 32'd0;
            for (int i = 0; i < 32; i++) ex[i] = shadow_m[i];
            if (q[0].we && q[0].rd != 5'd0) begin
                ewb = 32'd1 << q[0].rd;
                ex[q[0].rd] = q[0].data;
            end
            chk("order", order, popped_m + 64'd1);
            chk("insn", {32'd0, insn}, {32'd0, q[0].insn});
            chk("pc_rdata", {32'd0, pc_rdata}, {32'd0, q[0].pc});
            chk("pc_wdata", {32'd0, pc_wdata}, {32'd0, q[0].npc});
            chk("flags", {58'd0, trap, halt, mode, ixl}, {58'd0, q[0].trap, q[0].halt, q[0].mode, q[0].ixl});
            chk("intr", {63'd0, intr}, {63'd0, after_trap_m});
            chk("x_wb", {32'd0, x_wb}, {32'd0, ewb});
            n_checks++;
            if (x_wdata !== ex) begin
                n_err++;
                for (int i = 0; i < 32; i++)
                    if (x_wdata[i] !== ex[i])
                        $display("FAIL x_wdata[%0d]: got %0h expected %0h at %0t", i, x_wdata[i], ex[i], $time);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [31:0] i_insn, input logic [31:0] i_pc, input logic we,
                        input logic [4:0] rd, input logic [31:0] data, input logic tr);
        logic acc;
        int   budget;
        in_valid = 1'b1; in_insn = i_insn; in_pc = i_pc; in_next_pc = i_pc + 32'd4;
        in_trap = tr; in_halt = i_insn[31]; in_mode = i_pc[3:2]; in_ixl = 2'd1;
        in_rd_we = we; in_rd_addr = rd; in_rd_data = data;
        budget = 0;
        do begin
            acc = in_ready;
            @(posedge clk); #2;
            budget++;
        end while (!acc && budget < 20);
        if (!acc) begin
            n_checks++; n_err++;
            $display("FAIL send_timeout: event %0h not accepted within 20 cycles", i_insn);
        end
        in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    initial begin
        #1 reset = 1'b1;
        cycles(2);
        // reset state
        chk("rst_valid", {63'd0, valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_order", order, 64'd0);
        reset = 1'b0;
        cycles(1);

        // first event: addi x1,x0,5
        send(32'h00500093, 32'h80000000, 1'b1, 5'd1, 32'd5, 1'b0);
        @(negedge clk);
        chk("t1_valid", {63'd0, valid}, 64'd1);
        chk("t1_order", order, 64'd1);
        chk("t1_x_wb", {32'd0, x_wb}, 64'h2);
        chk("t1_x1", {32'd0, x_wdata[1]}, 64'd5);

        // write to x0 is dropped
        send(32'h0000f013, 32'h80000004, 1'b1, 5'd0, 32'h0000ffff, 1'b0);
        @(negedge clk);
        chk("t2_x_wb", {32'd0, x_wb}, 64'd0);
        chk("t2_x0", {32'd0, x_wdata[0]}, 64'd0);
        chk("t2_order", order, 64'd2);
        @(posedge clk); #2;

        // fill the FIFO with the consumer stalled
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++)
            send(32'h00000013 + (k << 20), 32'h80000010 + k * 4, 1'b1, 5'(k + 10), 32'h100 + k, 1'b0);
        chk("t3_full", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_head_order", order, 64'd3);
        @(posedge clk); #2;
        chk("t3_ready_after_pop", {63'd0, in_ready}, 64'd1);
        cycles(DEPTH);

        // trap record then two normal records, popped one at a time
        out_ready = 1'b0;
        send(32'h00000073, 32'h80000100, 1'b1, 5'd3, 32'h33, 1'b1);
        send(32'h00100113, 32'h80000200, 1'b1, 5'd2, 32'h44, 1'b0);
        send(32'h80000013, 32'h80000204, 1'b0, 5'd0, 32'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_intr", {63'd0, intr}, {63'd0, k == 1});
            out_ready = 1'b1;
            @(posedge clk); #2;
            out_ready = 1'b0;
        end
        out_ready = 1'b1;

        // back-to-back writes to x5
        send(32'h00a00293, 32'h80000300, 1'b1, 5'd5, 32'hA, 1'b0);
        send(32'h00b00293, 32'h80000304, 1'b1, 5'd5, 32'hB, 1'b0);
        send(32'h00000013, 32'h80000308, 1'b0, 5'd5, 32'hDEAD, 1'b0);
        @(negedge clk);
        chk("t5_x5", {32'd0, x_wdata[5]}, 64'hB);
        chk("t5_x3_trap_write", {32'd0, x_wdata[3]}, 64'h33);
        @(posedge clk); #2;

        // reset with records queued
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            send(32'h00100093, 32'h80000400 + k * 4, 1'b1, 5'd7, 32'h77, 1'b0);
        #1 reset = 1'b1;
        #1 chk("t6_valid_in_reset", {63'd0, valid}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        send(32'h00000013, 32'h80000000, 1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("t6_order", order, 64'd1);
        chk("t6_x_zero", {63'd0, |x_wdata}, 64'd0);
        cycles(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
